// File: rtl/klt_pkg.sv
// Shared field positions, widths, FSM state and stage bundle
// for the gradient_products pipeline.
package klt_pkg;

  localparam int PIX_MSB = 10;
  localparam int PIX_LSB = 3;
  localparam int DE_BIT  = 2;
  localparam int HS_BIT  = 1;
  localparam int VS_BIT  = 0;

  localparam int TAP_W   = 11;
  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 9;
  localparam int PROD_W  = 16;
  localparam int XPROD_W = 17;
  localparam int COORD_W = 11;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0]   pix;
    logic               de;
    logic               hs;
    logic               vs;
    logic               valid;
    logic               border;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [GRAD_W-1:0]  ix;
    logic [GRAD_W-1:0]  iy;
  } stg_t;

endpackage

// File: rtl/grad_coord_counter.sv
// Pixel x/y coordinate counters and frame-lock FSM
// for the gradient_products pipeline.
module grad_coord_counter
  import klt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_i,
  input  logic               vs_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               active_o
);

  localparam logic [COORD_W-1:0] X_MAX = '1;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               de_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_FRAME;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FRAME: if (vs_i) state_d = ACTIVE;
      ACTIVE:     state_d = ACTIVE;
    endcase
  end

  // v_sync clear takes priority over a coincident line end
  always_comb begin
    x_d = '0;
    if (de_i) begin
      x_d = (x_q == X_MAX) ? x_q : x_q + 1'b1;
    end
    y_d = y_q;
    priority case (1'b1)
      vs_i:           y_d = '0;
      de_q && !de_i:  y_d = y_q + 1'b1;
      default:        y_d = y_q;
    endcase
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign active_o = (state_q == ACTIVE);

endmodule

// File: rtl/gradient_products.sv
// Two-stage gradient and structure-tensor product pipeline.
// Define GRAD_PRODUCTS_EN to build the ixx/iyy/ixy multipliers.
module gradient_products
  import klt_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      context_valid,
  input  logic [TAP_W-1:0]          center,
  input  logic [TAP_W-1:0]          up,
  input  logic [TAP_W-1:0]          down,
  input  logic [TAP_W-1:0]          left,
  input  logic [TAP_W-1:0]          right,
  output logic                      grad_valid,
  output logic                      border,
  output logic signed [GRAD_W-1:0]  ix,
  output logic signed [GRAD_W-1:0]  iy,
  output logic [PROD_W-1:0]         ixx,
  output logic [PROD_W-1:0]         iyy,
  output logic signed [XPROD_W-1:0] ixy,
  output logic [PIX_W-1:0]          pixel_out,
  output logic                      de_out,
  output logic                      h_sync_out,
  output logic                      v_sync_out,
  output logic [COORD_W-1:0]        x_out,
  output logic [COORD_W-1:0]        y_out
);

  localparam logic [COORD_W-1:0] X_LAST =
    COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST =
    COORD_W'(V_ACTIVE - 1);

  logic [COORD_W-1:0] x_c, y_c;
  logic               active_c;
  stg_t               s1_d, s1_q, s2_q;
  logic               unused_taps;

  assign unused_taps = ^{up[DE_BIT:0], down[DE_BIT:0],
                         left[DE_BIT:0], right[DE_BIT:0]};

  grad_coord_counter u_coord (
    .clk      (clk),
    .rst_n    (rst_n),
    .de_i     (center[DE_BIT]),
    .vs_i     (center[VS_BIT]),
    .x_o      (x_c),
    .y_o      (y_c),
    .active_o (active_c)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.pix    = center[PIX_MSB:PIX_LSB];
    s1_d.de     = center[DE_BIT];
    s1_d.hs     = center[HS_BIT];
    s1_d.vs     = center[VS_BIT];
    s1_d.x      = x_c;
    s1_d.y      = y_c;
    s1_d.valid  = active_c & center[DE_BIT];
    s1_d.border = (x_c == '0) | (x_c == X_LAST) |
                  (y_c == '0) | (y_c == Y_LAST) |
                  (~context_valid & center[DE_BIT]);
    // Gradients forced to zero off-frame and on edges
    if (s1_d.valid && !s1_d.border) begin
      s1_d.ix = {1'b0, right[PIX_MSB:PIX_LSB]} -
                {1'b0, left[PIX_MSB:PIX_LSB]};
      s1_d.iy = {1'b0, down[PIX_MSB:PIX_LSB]} -
                {1'b0, up[PIX_MSB:PIX_LSB]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

`ifdef GRAD_PRODUCTS_EN
  logic signed [GRAD_W-1:0]  ix1, iy1;
  logic [PROD_W-1:0]         ixx_q, iyy_q;
  logic signed [XPROD_W-1:0] ixy_q;

  assign ix1 = $signed(s1_q.ix);
  assign iy1 = $signed(s1_q.iy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ixx_q <= '0;
      iyy_q <= '0;
      ixy_q <= '0;
    end else begin
      ixx_q <= PROD_W'(ix1 * ix1);
      iyy_q <= PROD_W'(iy1 * iy1);
      ixy_q <= XPROD_W'(ix1 * iy1);
    end
  end

  assign ixx = ixx_q;
  assign iyy = iyy_q;
  assign ixy = ixy_q;
`else
  assign ixx = '0;
  assign iyy = '0;
  assign ixy = '0;
`endif

  assign grad_valid = s2_q.valid;
  assign border     = s2_q.border;
  assign ix         = $signed(s2_q.ix);
  assign iy         = $signed(s2_q.iy);
  assign pixel_out  = s2_q.pix;
  assign de_out     = s2_q.de;
  assign h_sync_out = s2_q.hs;
  assign v_sync_out = s2_q.vs;
  assign x_out      = s2_q.x;
  assign y_out      = s2_q.y;

endmodule

// File: tb/tb_gradient_products.sv
// Self-checking bench for gradient_products: table vectors
// plus frame sequences, checked through an expected-value queue.
module tb_gradient_products;

  localparam int H = 16;
  localparam int V = 12;
  localparam int TAB_X = 5;
  localparam int TAB_Y = 5;
  localparam int NTAB = 7;

  logic clk;
  logic rst_n;
  logic context_valid;
  logic [10:0] center, up, down, left, right;
  logic grad_valid, border;
  logic signed [8:0] ix, iy;
  logic [15:0] ixx, iyy;
  logic signed [16:0] ixy;
  logic [7:0] pixel_out;
  logic de_out, h_sync_out, v_sync_out;
  logic [10:0] x_out, y_out;

  gradient_products #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .context_valid(context_valid),
    .center(center), .up(up), .down(down),
    .left(left), .right(right),
    .grad_valid(grad_valid), .border(border),
    .ix(ix), .iy(iy), .ixx(ixx), .iyy(iyy), .ixy(ixy),
    .pixel_out(pixel_out), .de_out(de_out),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .x_out(x_out), .y_out(y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_n, ctx, de, hs, vs;
    logic [7:0] c, l, r, u, d;
  } in_t;

  typedef struct {
    logic v, b;
    logic signed [8:0] ix, iy;
    logic [15:0] ixx, iyy;
    logic signed [16:0] ixy;
    logic [7:0] pix;
    logic de, hs, vs;
    logic [10:0] x, y;
    bit chk;
  } exp_t;

  typedef struct {
    logic [7:0] l, r, u, d;
    bit ctx;
    int eix, eiy, eixx, eiyy, eixy;
    bit eb;
  } vec_t;

  vec_t tab[NTAB];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  string phase = "reset";

  function automatic exp_t zero();
    exp_t z;
    z = '{default:'0};
    z.chk = 1'b1;
    return z;
  endfunction

  function automatic in_t rin(bit de, bit hs, bit vs);
    in_t i;
    i.rst_n = 1'b1;
    i.ctx = 1'b1;
    i.de = de;
    i.hs = hs;
    i.vs = vs;
    i.c = 8'($urandom);
    i.l = 8'($urandom);
    i.r = 8'($urandom);
    i.u = 8'($urandom);
    i.d = 8'($urandom);
    return i;
  endfunction

  function automatic exp_t mk(in_t i, bit act, int x, int y,
                              bit chk);
    exp_t e;
    int gx, gy;
    bit b;
    e = '{default:'0};
    e.pix = i.c;
    e.de = i.de;
    e.hs = i.hs;
    e.vs = i.vs;
    e.chk = chk;
    e.x = 11'(x);
    e.y = 11'(y);
    b = (x == 0) || (x == H - 1) || (y == 0) || (y == V - 1) ||
        (!i.ctx && i.de);
    e.b = b;
    e.v = act && i.de;
    if (e.v && !b) begin
      gx = int'(i.r) - int'(i.l);
      gy = int'(i.d) - int'(i.u);
      e.ix = 9'(gx);
      e.iy = 9'(gy);
`ifdef GRAD_PRODUCTS_EN
      e.ixx = 16'(gx * gx);
      e.iyy = 16'(gy * gy);
      e.ixy = 17'(gx * gy);
`endif
    end
    return e;
  endfunction

  task automatic check(input exp_t e);
    bit bad;
    checks++;
    bad = (grad_valid !== e.v) || (ix !== e.ix) ||
          (iy !== e.iy) || (ixx !== e.ixx) ||
          (iyy !== e.iyy) || (ixy !== e.ixy) ||
          (pixel_out !== e.pix) || (de_out !== e.de) ||
          (h_sync_out !== e.hs) || (v_sync_out !== e.vs);
    if (e.chk) begin
      bad = bad || (border !== e.b) ||
            (x_out !== e.x) || (y_out !== e.y);
    end
    if (bad) begin
      errors++;
      $display({"FAIL %s #%0d: got v=%0d b=%0d ix=%0d iy=%0d ",
                "ixx=%0d iyy=%0d ixy=%0d pix=%0d dhv=%0d%0d%0d ",
                "x=%0d y=%0d; required v=%0d b=%0d ix=%0d iy=%0d ",
                "ixx=%0d iyy=%0d ixy=%0d pix=%0d dhv=%0d%0d%0d ",
                "x=%0d y=%0d (xy/b checked=%0d)"},
               phase, checks, grad_valid, border, ix, iy,
               ixx, iyy, ixy, pixel_out, de_out, h_sync_out,
               v_sync_out, x_out, y_out, e.v, e.b, e.ix, e.iy,
               e.ixx, e.iyy, e.ixy, e.pix, e.de, e.hs, e.vs,
               e.x, e.y, e.chk);
    end
  endtask

  task automatic apply(input in_t i, input exp_t e);
    rst_n = i.rst_n;
    context_valid = i.ctx;
    center = {i.c, i.de, i.hs, i.vs};
    up = {i.u, i.de & i.ctx, 2'b00};
    down = {i.d, i.de & i.ctx, 2'b00};
    left = {i.l, i.de & i.ctx, 2'b00};
    right = {i.r, i.de & i.ctx, 2'b00};
    if (!i.rst_n) begin
      q.delete();
      q.push_back(zero());
      q.push_back(zero());
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (q.size() >= 2) check(q.pop_front());
  endtask

  task automatic run_line(input int y, input int n, input bit act,
                          input bit chk, input bit fall_vs);
    in_t i;
    exp_t e;
    int xs, k;
    for (int x = 0; x < n; x++) begin
      i = rin(1'b1, 1'b0, 1'b0);
      if (y == 3 && x == 7) i.ctx = 1'b0;
      xs = (x > 2047) ? 2047 : x;
      k = x - TAB_X;
      if (act && y == TAB_Y && k >= 0 && k < NTAB) begin
        i.l = tab[k].l;
        i.r = tab[k].r;
        i.u = tab[k].u;
        i.d = tab[k].d;
        i.ctx = tab[k].ctx;
        e = mk(i, act, xs, y, chk);
        e.b = tab[k].eb;
        e.ix = 9'(tab[k].eix);
        e.iy = 9'(tab[k].eiy);
`ifdef GRAD_PRODUCTS_EN
        e.ixx = 16'(tab[k].eixx);
        e.iyy = 16'(tab[k].eiyy);
        e.ixy = 17'(tab[k].eixy);
`endif
      end else begin
        e = mk(i, act, xs, y, chk);
      end
      apply(i, e);
    end
    for (int b = 0; b < 3; b++) begin
      i = rin(1'b0, b == 0, fall_vs);
      apply(i, mk(i, act, 0, 0, 1'b0));
    end
  endtask

  initial begin
    in_t i;
    tab[0] = '{8'd10, 8'd200, 8'd250, 8'd4, 1'b1,
               190, -246, 36100, 60516, -46740, 1'b0};
    tab[1] = '{8'd0, 8'd255, 8'd255, 8'd0, 1'b1,
               255, -255, 65025, 65025, -65025, 1'b0};
    tab[2] = '{8'd255, 8'd0, 8'd0, 8'd255, 1'b1,
               -255, 255, 65025, 65025, -65025, 1'b0};
    tab[3] = '{8'd50, 8'd50, 8'd7, 8'd7, 1'b1,
               0, 0, 0, 0, 0, 1'b0};
    tab[4] = '{8'd100, 8'd97, 8'd20, 8'd30, 1'b1,
               -3, 10, 9, 100, -30, 1'b0};
    tab[5] = '{8'd1, 8'd2, 8'd3, 8'd9, 1'b0,
               0, 0, 0, 0, 0, 1'b1};
    tab[6] = '{8'd0, 8'd128, 8'd128, 8'd0, 1'b1,
               128, -128, 16384, 16384, -16384, 1'b0};

    phase = "reset";
    for (int c = 0; c < 3; c++) begin
      i = rin(1'($urandom), 1'($urandom), 1'($urandom));
      i.rst_n = 1'b0;
      apply(i, zero());
    end

    phase = "no_vsync";
    for (int y = 0; y < 2; y++) run_line(y, H, 1'b0, 1'b0, 1'b0);

    phase = "vsync";
    for (int c = 0; c < 4; c++) begin
      i = rin(1'b0, 1'b0, c < 3);
      apply(i, mk(i, 1'b1, 0, 0, 1'b0));
    end

    phase = "frame";
    for (int y = 0; y < V; y++) begin
      run_line(y, H, 1'b1, 1'b1, y == V - 1);
    end

    phase = "x_saturate";
    run_line(0, 2100, 1'b1, 1'b1, 1'b0);

    phase = "mid_reset";
    for (int x = 0; x < 4; x++) begin
      i = rin(1'b1, 1'b0, 1'b0);
      apply(i, mk(i, 1'b1, x, 1, 1'b1));
    end
    for (int c = 0; c < 2; c++) begin
      i = rin(1'b1, 1'b0, 1'b0);
      i.rst_n = 1'b0;
      apply(i, zero());
    end
    run_line(0, 6, 1'b0, 1'b0, 1'b0);

    phase = "relock";
    for (int c = 0; c < 3; c++) begin
      i = rin(1'b0, 1'b0, c < 2);
      apply(i, mk(i, 1'b1, 0, 0, 1'b0));
    end
    run_line(0, 6, 1'b1, 1'b1, 1'b0);
    run_line(1, 6, 1'b1, 1'b1, 1'b0);

    phase = "drain";
    for (int c = 0; c < 2; c++) begin
      i = rin(1'b0, 1'b0, 1'b0);
      apply(i, mk(i, 1'b1, 0, 0, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
